// File: rtl/fft_twiddle_seq_pkg.sv
// Shared FFT definitions: default table depth, twiddle index width and the
// sequencer state encoding used by fft_twiddle_seq and the twiddle lookups.
package fft_twiddle_seq_pkg;

  localparam int FFT_MAX_LOG2N = 7;
  localparam int TW_IDX_W      = FFT_MAX_LOG2N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fft_twiddle_seq_bf_addr_gen.sv
// Combinational DIF butterfly addressing: (L, s, c) -> operand pair and the
// full-circle twiddle index scaled to the 2^MAX_LOG2N table.
module fft_bf_addr_gen
  import fft_twiddle_seq_pkg::*;
#(
  parameter int MAX_LOG2N = FFT_MAX_LOG2N
) (
  input  logic [2:0]           log2n,
  input  logic [2:0]           stage,
  input  logic [MAX_LOG2N-1:0] cnt,
  output logic [MAX_LOG2N-1:0] addr_a,
  output logic [MAX_LOG2N-1:0] addr_b,
  output logic [MAX_LOG2N-1:0] tw_idx
);

  localparam logic [2:0]           MAX_L   = 3'(MAX_LOG2N);
  localparam logic [MAX_LOG2N-1:0] ADDR_ONE = {{(MAX_LOG2N-1){1'b0}}, 1'b1};

  logic [2:0]           span_sh;
  logic [2:0]           tw_sh;
  logic [MAX_LOG2N-1:0] span;
  logic [MAX_LOG2N-1:0] pos;
  logic [MAX_LOG2N-1:0] grp;

  // span is a power of two, so mod/div reduce to mask/shift
  always_comb begin
    span_sh = log2n - stage - 3'd1;
    tw_sh   = MAX_L - log2n;
    span    = ADDR_ONE << span_sh;
    pos     = cnt & (span - ADDR_ONE);
    grp     = cnt >> span_sh;
    addr_a  = (grp << (span_sh + 3'd1)) | pos;
    addr_b  = addr_a + span;
    tw_idx  = (pos << stage) << tw_sh;
  end

endmodule

// File: rtl/fft_twiddle_seq.sv
// FFT stage/butterfly sequencer: walks stages and butterflies of a DIF
// transform, issuing registered descriptors over a valid/ready handshake.
module fft_twiddle_seq
  import fft_twiddle_seq_pkg::*;
#(
  parameter int MAX_LOG2N = FFT_MAX_LOG2N,
  parameter int STAGE_GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           cfg_log2n,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 bf_valid,
  input  logic                 bf_ready,
  output logic [2:0]           bf_stage,
  output logic [MAX_LOG2N-1:0] bf_addr_a,
  output logic [MAX_LOG2N-1:0] bf_addr_b,
  output logic [MAX_LOG2N-1:0] tw_idx,
  output logic                 bf_last
);

  localparam logic [2:0]           MAX_L    = 3'(MAX_LOG2N);
  localparam logic [3:0]           GAP_LAST = 4'(STAGE_GAP - 1);
  localparam logic [MAX_LOG2N-1:0] CNT_ONE  = {{(MAX_LOG2N-1){1'b0}}, 1'b1};

  fsm_state_e           state_q, state_d;
  logic [2:0]           log2n_q, log2n_d;
  logic [2:0]           stage_q, stage_d;
  logic [MAX_LOG2N-1:0] cnt_q, cnt_d;
  logic [3:0]           gap_q, gap_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 bf_valid_q, bf_valid_d;
  logic                 bf_last_q, bf_last_d;
  logic [2:0]           bf_stage_q, bf_stage_d;
  logic [MAX_LOG2N-1:0] bf_addr_a_q, bf_addr_a_d;
  logic [MAX_LOG2N-1:0] bf_addr_b_q, bf_addr_b_d;
  logic [MAX_LOG2N-1:0] tw_idx_q, tw_idx_d;

  logic                 hs;
  logic                 cfg_legal;
  logic [MAX_LOG2N-1:0] cnt_last_q;
  logic [MAX_LOG2N-1:0] cnt_last_d;
  logic [MAX_LOG2N-1:0] gen_addr_a;
  logic [MAX_LOG2N-1:0] gen_addr_b;
  logic [MAX_LOG2N-1:0] gen_tw_idx;

  assign hs         = bf_valid_q & bf_ready;
  assign cfg_legal  = (cfg_log2n >= 3'd3) && (cfg_log2n <= MAX_L);
  assign cnt_last_q = (CNT_ONE << (log2n_q - 3'd1)) - CNT_ONE;
  assign cnt_last_d = (CNT_ONE << (log2n_d - 3'd1)) - CNT_ONE;

  always_comb begin
    state_d   = state_q;
    log2n_d   = log2n_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_legal) begin
            state_d = ST_ISSUE;
            log2n_d = cfg_log2n;
            stage_d = 3'd0;
            cnt_d   = '0;
            gap_d   = 4'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          if (cnt_q == cnt_last_q) begin
            cnt_d = '0;
            if (stage_q == log2n_q - 3'd1) begin
              state_d = ST_FIN;
            end else if (STAGE_GAP == 0) begin
              stage_d = stage_q + 3'd1;
            end else begin
              state_d = ST_GAP;
              gap_d   = 4'd0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_ISSUE;
          stage_d = stage_q + 3'd1;
          gap_d   = 4'd0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // abort outranks any handshake in flight
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      stage_d = 3'd0;
      cnt_d   = '0;
      gap_d   = 4'd0;
    end
  end

  fft_bf_addr_gen #(
    .MAX_LOG2N (MAX_LOG2N)
  ) u_addr_gen (
    .log2n  (log2n_d),
    .stage  (stage_d),
    .cnt    (cnt_d),
    .addr_a (gen_addr_a),
    .addr_b (gen_addr_b),
    .tw_idx (gen_tw_idx)
  );

  // Descriptor registers are loaded from next-state values, so a stall
  // (no counter change) naturally holds them stable.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
    bf_valid_d  = (state_d == ST_ISSUE);
    bf_stage_d  = bf_valid_d ? stage_d : 3'd0;
    bf_addr_a_d = bf_valid_d ? gen_addr_a : '0;
    bf_addr_b_d = bf_valid_d ? gen_addr_b : '0;
    tw_idx_d    = bf_valid_d ? gen_tw_idx : '0;
    bf_last_d   = bf_valid_d && (stage_d == log2n_d - 3'd1) && (cnt_d == cnt_last_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      log2n_q     <= 3'd0;
      stage_q     <= 3'd0;
      cnt_q       <= '0;
      gap_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      bf_valid_q  <= 1'b0;
      bf_last_q   <= 1'b0;
      bf_stage_q  <= 3'd0;
      bf_addr_a_q <= '0;
      bf_addr_b_q <= '0;
      tw_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      log2n_q     <= log2n_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      bf_valid_q  <= bf_valid_d;
      bf_last_q   <= bf_last_d;
      bf_stage_q  <= bf_stage_d;
      bf_addr_a_q <= bf_addr_a_d;
      bf_addr_b_q <= bf_addr_b_d;
      tw_idx_q    <= tw_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign bf_valid  = bf_valid_q;
  assign bf_last   = bf_last_q;
  assign bf_stage  = bf_stage_q;
  assign bf_addr_a = bf_addr_a_q;
  assign bf_addr_b = bf_addr_b_q;
  assign tw_idx    = tw_idx_q;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Directed bench for fft_twiddle_seq: hand-computed descriptor vectors,
// error/abort/reset scenarios and a stalled L=7 run against a loop model.
module tb_fft_twiddle_seq;

  localparam int MAXL = 7;
  localparam int GAP  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [2:0]      cfg_log2n;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic            bf_valid;
  logic            bf_ready;
  logic [2:0]      bf_stage;
  logic [MAXL-1:0] bf_addr_a;
  logic [MAXL-1:0] bf_addr_b;
  logic [MAXL-1:0] tw_idx;
  logic            bf_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_twiddle_seq #(
    .MAX_LOG2N (MAXL),
    .STAGE_GAP (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_log2n (cfg_log2n),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .bf_stage  (bf_stage),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .tw_idx    (tw_idx),
    .bf_last   (bf_last)
  );

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_idle: busy=%b required 0 within %0d cycles", busy, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bf_ready = 1'b0; cfg_log2n = 3'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, cfg_err, bf_valid, bf_last} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy/done/err/valid/last=%b required 00000",
               {busy, done, cfg_err, bf_valid, bf_last});
    end
    n_cmp++;
    if ({bf_stage, bf_addr_a, bf_addr_b, tw_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: stage=%0d a=%0d b=%0d tw=%0d required all 0",
               bf_stage, bf_addr_a, bf_addr_b, tw_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: released, busy=%b", busy);
  endtask

  task automatic test_l3_vectors();
    int exp_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int exp_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int exp_tw[12] = '{0, 16, 32, 48, 0, 32, 0, 32, 0, 0, 0, 0};
    int k, busy_cyc, done_cyc;
    logic [24:0] got, expv;
    k = 0; busy_cyc = 0; done_cyc = 0;
    cfg_log2n = 3'd3; start = 1'b1; bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (bf_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL l3_first_valid: bf_valid=%b required 1", bf_valid);
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy && !done) busy_cyc++;
      if (done) done_cyc++;
      if (bf_valid) begin
        got = {bf_stage, bf_last, bf_addr_a, bf_addr_b, tw_idx};
        if (k < 12) begin
          expv = {3'(k / 4), (k == 11), 7'(exp_a[k]), 7'(exp_b[k]), 7'(exp_tw[k])};
          n_cmp++;
          if (got !== expv) begin
            n_bad++;
            $display("FAIL l3_desc%0d: s=%0d last=%b a=%0d b=%0d tw=%0d required s=%0d last=%b a=%0d b=%0d tw=%0d",
                     k, bf_stage, bf_last, bf_addr_a, bf_addr_b, tw_idx,
                     k / 4, (k == 11), exp_a[k], exp_b[k], exp_tw[k]);
          end else begin
            $display("l3: desc %0d s=%0d a=%0d b=%0d tw=%0d last=%b",
                     k, bf_stage, bf_addr_a, bf_addr_b, tw_idx, bf_last);
          end
        end
        k++;
      end
      if (!busy) break;
    end
    n_cmp++;
    if (k !== 12) begin
      n_bad++;
      $display("FAIL l3_count: descriptors=%0d required 12", k);
    end
    n_cmp++;
    if (busy_cyc !== 16) begin
      n_bad++;
      $display("FAIL l3_busy_cycles: busy before done=%0d required 16", busy_cyc);
    end
    n_cmp++;
    if (done_cyc !== 1) begin
      n_bad++;
      $display("FAIL l3_done_cycles: done cycles=%0d required 1", done_cyc);
    end
  endtask

  task automatic test_cfg_err();
    logic [2:0] bad_cfg [2] = '{3'd0, 3'd2};
    for (int i = 0; i < 2; i++) begin
      cfg_log2n = bad_cfg[i]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({cfg_err, busy, bf_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL cfg_err_pulse L=%0d: err/busy/valid=%b required 100",
                 bad_cfg[i], {cfg_err, busy, bf_valid});
      end
      @(negedge clk);
      n_cmp++;
      if ({cfg_err, busy, bf_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL cfg_err_single L=%0d: err/busy/valid=%b required 000",
                 bad_cfg[i], {cfg_err, busy, bf_valid});
      end else begin
        $display("cfg_err: L=%0d rejected with single pulse", bad_cfg[i]);
      end
    end
    cfg_log2n = 3'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if ({cfg_err, busy, bf_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL start_abort_idle: err/busy/valid=%b required 000",
               {cfg_err, busy, bf_valid});
    end else begin
      $display("cfg_err: start+abort in idle stays idle");
    end
  endtask

  task automatic test_abort();
    bit found;
    int done_seen;
    found = 0; done_seen = 0;
    cfg_log2n = 3'd4; start = 1'b1; bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bf_valid && bf_stage == 3'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL abort_reach_stage1: stage=%0d valid=%b required stage 1 valid", bf_stage, bf_valid);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, bf_valid, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_idle: busy/valid/done=%b required 000", {busy, bf_valid, done});
    end
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: done cycles=%0d required 0", done_seen);
    end else begin
      $display("abort: returned to idle without done");
    end
    cfg_log2n = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({bf_valid, bf_stage, bf_addr_a, bf_addr_b, tw_idx} !== {1'b1, 3'd0, 7'd0, 7'd8, 7'd0}) begin
      n_bad++;
      $display("FAIL abort_restart: valid=%b s=%0d a=%0d b=%0d tw=%0d required 1 0 0 8 0",
               bf_valid, bf_stage, bf_addr_a, bf_addr_b, tw_idx);
    end else begin
      $display("abort: restart s=0 a=0 b=8 tw=0");
    end
    wait_idle(200);
  endtask

  task automatic test_l7_stalls();
    int ea[448], eb[448], etw[448], es[448];
    int n, span, idx, done_cnt, stalls;
    bit prev_stall, rdy;
    logic [24:0] got, prev_got, expv;
    n = 0;
    for (int s = 0; s < 7; s++) begin
      span = 128 >> (s + 1);
      for (int g = 0; g < 64 / span; g++) begin
        for (int p = 0; p < span; p++) begin
          ea[n]  = g * 2 * span + p;
          eb[n]  = ea[n] + span;
          etw[n] = ((p << s) << (MAXL - 7)) & 127;
          es[n]  = s;
          n++;
        end
      end
    end
    idx = 0; done_cnt = 0; stalls = 0; prev_stall = 0; prev_got = '0;
    cfg_log2n = 3'd7; start = 1'b1; bf_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) done_cnt++;
      if (bf_valid) begin
        got = {bf_stage, bf_last, bf_addr_a, bf_addr_b, tw_idx};
        if (prev_stall) begin
          n_cmp++;
          if (got !== prev_got) begin
            n_bad++;
            $display("FAIL l7_hold idx=%0d: desc=%h required held %h", idx, got, prev_got);
          end
        end
        if (idx >= 448) begin
          n_cmp++;
          n_bad++;
          $display("FAIL l7_extra: descriptor beyond 448, a=%0d", bf_addr_a);
          break;
        end
        expv = {3'(es[idx]), (idx == 447), 7'(ea[idx]), 7'(eb[idx]), 7'(etw[idx])};
        n_cmp++;
        if (got !== expv) begin
          n_bad++;
          $display("FAIL l7_desc%0d: s=%0d last=%b a=%0d b=%0d tw=%0d required s=%0d last=%b a=%0d b=%0d tw=%0d",
                   idx, bf_stage, bf_last, bf_addr_a, bf_addr_b, tw_idx,
                   es[idx], (idx == 447), ea[idx], eb[idx], etw[idx]);
        end
        rdy = ($urandom_range(0, 3) != 0);
        bf_ready = rdy;
        if (rdy) idx++;
        else stalls++;
        prev_stall = !rdy;
        prev_got = got;
      end else begin
        bf_ready = 1'($urandom_range(0, 1));
        prev_stall = 0;
      end
      if (!busy) break;
    end
    n_cmp++;
    if (idx !== 448) begin
      n_bad++;
      $display("FAIL l7_count: descriptors=%0d required 448", idx);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL l7_done: done cycles=%0d required 1", done_cnt);
    end
    $display("l7: %0d descriptors, %0d stall cycles", idx, stalls);
    bf_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    cfg_log2n = 3'd5; start = 1'b1; bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({busy, bf_valid, bf_stage, bf_addr_a, bf_addr_b, tw_idx} !==
          {1'b1, 1'b1, 3'd0, 7'(i), 7'(i + 16), 7'(i * 4)}) begin
        n_bad++;
        $display("FAIL busy_start c=%0d: busy=%b valid=%b s=%0d a=%0d b=%0d tw=%0d required 1 1 0 %0d %0d %0d",
                 i, busy, bf_valid, bf_stage, bf_addr_a, bf_addr_b, tw_idx, i, i + 16, i * 4);
      end else begin
        $display("reset_mid: c=%0d a=%0d b=%0d tw=%0d", i, bf_addr_a, bf_addr_b, tw_idx);
      end
      if (i == 1) begin
        start = 1'b1; cfg_log2n = 3'd3;
      end else begin
        start = 1'b0;
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({busy, done, cfg_err, bf_valid, bf_last, bf_stage, bf_addr_a, bf_addr_b, tw_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b valid=%b last=%b s=%0d a=%0d b=%0d tw=%0d required all 0",
               busy, done, cfg_err, bf_valid, bf_last, bf_stage, bf_addr_a, bf_addr_b, tw_idx);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, bf_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_idle: busy/valid=%b required 00", {busy, bf_valid});
    end else begin
      $display("reset_mid: outputs cleared and idle");
    end
  endtask

  initial begin
    test_reset();
    test_l3_vectors();
    test_cfg_err();
    test_abort();
    test_l7_stalls();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
